// File: rtl/alu_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_host_pkg
// Description : Shared types and constants for the ALU pin-side host interface.
// Revision    : 1.0
// ============================================================================
package alu_host_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd8;

    // Z and N together cannot come out of the core, so this marks a timeout
    localparam logic [7:0] ERR_RESULT = 8'hEE;
    localparam logic [3:0] ERR_FLAGS  = 4'hF;

    localparam logic [7:0] UIO_OE = 8'hFC;

    localparam int UIO_STROBE_BIT = 0;
    localparam int UIO_ABORT_BIT  = 1;
    localparam int UIO_BUSY_BIT   = 2;
    localparam int UIO_VALID_BIT  = 3;
    localparam int UIO_FLAGS_LSB  = 4;
    localparam int OPC_UNARY_BIT  = 7;

endpackage
`default_nettype wire

// File: rtl/alu_host_if_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_host_if_if
// Description : Start/done handshake bundle between host block and ALU core.
// Revision    : 1.0
// ============================================================================
interface alu_host_if_if;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_start;
    logic       alu_done;
    logic [7:0] alu_y;
    logic [3:0] alu_flags;

    modport master (
        output alu_op, alu_a, alu_b, alu_start,
        input  alu_done, alu_y, alu_flags
    );

    modport slave (
        input  alu_op, alu_a, alu_b, alu_start,
        output alu_done, alu_y, alu_flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_host_sync.sv
`default_nettype none
// ============================================================================
// Module      : alu_host_sync
// Description : 2-FF pad synchronizer with enable, level and rising-edge out.
// Revision    : 1.0
// ============================================================================
module alu_host_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic ena,
    input  wire logic d,
    output logic      level,
    output logic      rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else if (ena) begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/alu_host_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_host_if
// Description : Collects opcode/A/B bytes from pads, issues them to the ALU
//               core and holds the result and flags on the output pins.
// Revision    : 1.0
// ============================================================================
module alu_host_if
    import alu_host_pkg::*;
#(
    parameter int ALU_TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ena,
    input  wire logic [7:0] ui_in,
    input  wire logic [7:0] uio_in,
    output logic      [7:0] uo_out,
    output logic      [7:0] uio_out,
    output logic      [7:0] uio_oe,
    alu_host_if_if.master   alu
);
    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    state_t           r_state, w_state_nx;
    logic [3:0]       r_op, w_op_nx;
    logic [7:0]       r_a, w_a_nx;
    logic [7:0]       r_b, w_b_nx;
    logic             r_unary, w_unary_nx;
    logic [7:0]       r_result, w_result_nx;
    logic [3:0]       r_flags, w_flags_nx;
    logic             r_valid, w_valid_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic             w_strobe_rise, w_strobe_level;
    logic             w_abort_level, w_abort_rise;
    logic             w_busy;
    logic             w_unused_sig;

    assign w_unused_sig = &{1'b0, uio_in[7:2], w_strobe_level, w_abort_rise};

    alu_host_sync u_sync_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (uio_in[UIO_STROBE_BIT]),
        .level (w_strobe_level),
        .rise  (w_strobe_rise)
    );

    alu_host_sync u_sync_abort (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (uio_in[UIO_ABORT_BIT]),
        .level (w_abort_level),
        .rise  (w_abort_rise)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nx  = r_state;
        w_op_nx     = r_op;
        w_a_nx      = r_a;
        w_b_nx      = r_b;
        w_unary_nx  = r_unary;
        w_result_nx = r_result;
        w_flags_nx  = r_flags;
        w_valid_nx  = r_valid;
        w_cnt_nx    = r_cnt;
        if (w_abort_level) begin
            w_state_nx  = IDLE;
            w_valid_nx  = 1'b0;
            w_result_nx = 8'h00;
            w_flags_nx  = 4'h0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_strobe_rise) begin
                        w_op_nx    = ui_in[3:0];
                        w_unary_nx = ui_in[OPC_UNARY_BIT];
                        if (ui_in[OPC_UNARY_BIT]) begin
                            w_b_nx = 8'h00;
                        end
                        w_valid_nx = 1'b0;
                        w_state_nx = GET_A;
                    end
                end
                GET_A: begin
                    if (w_strobe_rise) begin
                        w_a_nx     = ui_in;
                        w_state_nx = r_unary ? ISSUE : GET_B;
                    end
                end
                GET_B: begin
                    if (w_strobe_rise) begin
                        w_b_nx     = ui_in;
                        w_state_nx = ISSUE;
                    end
                end
                ISSUE: begin
                    w_cnt_nx   = '0;
                    w_state_nx = WAIT;
                end
                WAIT: begin
                    w_cnt_nx = w_cnt_inc;
                    // a done pulse on the timeout edge still delivers the real result
                    if (alu.alu_done) begin
                        w_result_nx = alu.alu_y;
                        w_flags_nx  = alu.alu_flags;
                        w_valid_nx  = 1'b1;
                        w_state_nx  = DONE;
                    end else if (w_cnt_inc == CNT_W'(ALU_TIMEOUT)) begin
                        w_result_nx = ERR_RESULT;
                        w_flags_nx  = ERR_FLAGS;
                        w_valid_nx  = 1'b1;
                        w_state_nx  = DONE;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= 4'h0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_unary  <= 1'b0;
            r_result <= 8'h00;
            r_flags  <= 4'h0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else if (ena) begin
            r_state  <= w_state_nx;
            r_op     <= w_op_nx;
            r_a      <= w_a_nx;
            r_b      <= w_b_nx;
            r_unary  <= w_unary_nx;
            r_result <= w_result_nx;
            r_flags  <= w_flags_nx;
            r_valid  <= w_valid_nx;
            r_cnt    <= w_cnt_nx;
        end
    end

    assign w_busy        = (r_state == ISSUE) || (r_state == WAIT);
    assign alu.alu_start = (r_state == ISSUE);
    assign alu.alu_op    = r_op;
    assign alu.alu_a     = r_a;
    assign alu.alu_b     = r_b;
    assign uo_out        = r_result;
    assign uio_oe        = UIO_OE;

    always_comb begin
        uio_out                         = 8'h00;
        uio_out[UIO_FLAGS_LSB +: 4]     = r_flags;
        uio_out[UIO_VALID_BIT]          = r_valid;
        uio_out[UIO_BUSY_BIT]           = w_busy;
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_host_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_host_if
// Description : Scoreboard bench for alu_host_if with a behavioural ALU core.
// Revision    : 1.0
// ============================================================================
module tb_alu_host_if;
    import alu_host_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    alu_host_if_if bus ();

    alu_host_if #(.ALU_TIMEOUT(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .alu     (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    int          model_delay = -1;
    logic [7:0]  model_y     = 8'h00;
    logic [3:0]  model_flags = 4'h0;
    int          start_count = 0;
    logic [3:0]  last_op;
    logic [7:0]  last_a;
    logic [7:0]  last_b;
    logic        mon_prev = 1'b0;
    logic [11:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural core: answers model_delay negedges after seeing start
    initial begin
        bus.alu_done  = 1'b0;
        bus.alu_y     = 8'h00;
        bus.alu_flags = 4'h0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                start_count++;
                last_op = bus.alu_op;
                last_a  = bus.alu_a;
                last_b  = bus.alu_b;
                if (model_delay >= 0) begin
                    repeat (model_delay) @(negedge clk);
                    bus.alu_done  = 1'b1;
                    bus.alu_y     = model_y;
                    bus.alu_flags = model_flags;
                    @(negedge clk);
                    bus.alu_done  = 1'b0;
                end
            end
        end
    end

    // Monitor: every rising valid must match the oldest expected result
    initial begin
        forever begin
            @(negedge clk);
            if (uio_out[3] && !mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", uo_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({uo_out, uio_out[7:4], uio_out[2]} !== {mon_exp, 1'b0}) begin
                        errors++;
                        $display("FAIL result actual={y=%0h fl=%0h busy=%0b} required={y=%0h fl=%0h busy=0}",
                                 uo_out, uio_out[7:4], uio_out[2], mon_exp[11:4], mon_exp[3:0]);
                    end
                end
            end
            mon_prev = uio_out[3];
        end
    end

    task automatic send_byte(input logic [7:0] b);
        ui_in     = b;
        uio_in[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 uio_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!uio_out[3] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_timeout"}, uio_out[3], 1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] y, input logic [3:0] fl,
                             input int delay, input logic err, input logic chk_clear);
        int s0;
        model_y     = y;
        model_flags = fl;
        model_delay = delay;
        exp_q.push_back(err ? {ERR_RESULT, ERR_FLAGS} : {y, fl});
        s0 = start_count;
        if (chk_clear) begin
            ui_in     = op;
            uio_in[0] = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check({tag, "_valid_clear"}, uio_out[3], 0);
            @(posedge clk);
            #1 uio_in[0] = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end else begin
            send_byte(op);
        end
        send_byte(a);
        if (!op[7]) send_byte(b);
        wait_valid(tag);
        check({tag, "_start_pulses"}, start_count - s0, 1);
        check({tag, "_alu_op"}, last_op, op[3:0]);
        check({tag, "_alu_a"}, last_a, a);
        check({tag, "_alu_b"}, last_b, op[7] ? 8'h00 : b);
    endtask

    initial begin
        int s0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hFC);
        check("rst_alu_bus", {bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame("add", {4'h0, OP_ADD}, 8'h12, 8'h34, 8'h46, 4'b0000, 3, 1'b0, 1'b0);
        run_frame("not", {4'h8, OP_NOT}, 8'h0F, 8'h55, 8'hF0, 4'b0100, 2, 1'b0, 1'b0);
        run_frame("timeout", {4'h0, OP_SUB}, 8'h05, 8'h03, 8'h02, 4'b0000, -1, 1'b1, 1'b0);
        run_frame("done_at_15", {4'h0, OP_ADD}, 8'h01, 8'h01, 8'h02, 4'b0000, 15, 1'b0, 1'b0);

        // Stray strobe while the core is still busy
        model_y     = 8'hF0;
        model_flags = 4'b0100;
        model_delay = 10;
        exp_q.push_back({8'hF0, 4'b0100});
        send_byte({4'h0, OP_XOR});
        send_byte(8'hFF);
        send_byte(8'h0F);
        check("wait_busy", uio_out[2], 1);
        send_byte(8'h88);
        wait_valid("wait_discard");
        check("wait_discard_alu_op", bus.alu_op, OP_XOR);

        run_frame("shl_clear", {4'h0, OP_SHL}, 8'h81, 8'h01, 8'h02, 4'b0010, 1, 1'b0, 1'b1);

        // Abort coincident with the B strobe
        model_delay = 3;
        s0 = start_count;
        send_byte({4'h0, OP_SUB});
        send_byte(8'h20);
        ui_in     = 8'h05;
        uio_in[0] = 1'b1;
        uio_in[1] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {uo_out, uio_out}, 16'h0000);
        @(posedge clk);
        #1 uio_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_issue", start_count - s0, 0);
        run_frame("after_abort", {4'h0, OP_SUB}, 8'h50, 8'h20, 8'h30, 4'b0000, 3, 1'b0, 1'b0);

        // Asynchronous reset mid-WAIT, then a late done must be ignored
        model_y     = 8'h99;
        model_flags = 4'b0000;
        model_delay = 8;
        send_byte({4'h0, OP_OR});
        send_byte(8'h11);
        send_byte(8'h22);
        check("prereset_busy", uio_out[2], 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_uo_out", uo_out, 8'h00);
        check("arst_uio_out", uio_out, 8'h00);
        check("arst_uio_oe", uio_oe, 8'hFC);
        check("arst_alu_bus", {bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("late_done_ignored", {uo_out, uio_out}, 16'h0000);

        // Strobe with ena low must not be taken as an opcode
        @(posedge clk);
        #1 ena = 1'b0;
        send_byte(8'h00);
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_frame("ena_and", {4'h0, OP_AND}, 8'hF0, 8'h3C, 8'h30, 4'b0000, 2, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
